// File: rtl/iq_mavg_pipe.sv
// Purpose : I/Q integrate-and-dump averager (N = 2**LOG2_N samples per block) with a bypass mode.
// Latency : one cycle from the accepting edge of the Nth sample (or of each sample in bypass) to out_valid.
// Backpr. : in_ready drops while a result is held (out_valid && !out_ready), on a mode change and in reset.
//
// Ports:
//   clk, reset           single rising-edge clock, synchronous active-high reset
//   mode                 0 = average, 1 = bypass
//   in_valid/in_ready    input handshake for x_i/x_q (signed, DW bits)
//   out_valid/out_ready  output handshake for y_out_i/y_out_q (signed, DW bits)
//   blk_cnt              samples accumulated in the current block (1 bit, always 0 when LOG2_N = 0)
//
// Build option: define IQ_MAVG_ROUND_EN to round the average half toward +inf
// instead of flooring. Bypass output is unaffected by it.

module iq_mavg_pipe #(
    parameter int DW     = 16,
    parameter int LOG2_N = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   mode,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic signed [DW-1:0]                   x_i,
    input  logic signed [DW-1:0]                   x_q,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic signed [DW-1:0]                   y_out_i,
    output logic signed [DW-1:0]                   y_out_q,
    output logic [((LOG2_N > 0) ? LOG2_N : 1)-1:0] blk_cnt
);

    localparam int CW = (LOG2_N > 0) ? LOG2_N : 1;
    localparam int N  = 1 << LOG2_N;
    // Holds N full-scale samples plus the rounding offset without overflow.
    localparam int AW = DW + LOG2_N;

`ifdef IQ_MAVG_ROUND_EN
    localparam logic signed [AW-1:0] RND = AW'((1 << LOG2_N) >> 1);
`else
    localparam logic signed [AW-1:0] RND = AW'(0);
`endif

    logic signed [AW-1:0] acc_i;
    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] sum_i;
    logic signed [AW-1:0] sum_q;
    logic [CW-1:0]        cnt;
    logic                 mode_r;
    logic                 mode_chg;
    logic                 accept;
    logic                 blk_last;

    assign mode_chg = (mode != mode_r);
    assign in_ready = !reset && !mode_chg && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    // With LOG2_N = 0 the compare is against 0 and cnt never leaves 0,
    // so every sample closes a block.
    assign blk_last = (cnt == CW'(N - 1));
    assign blk_cnt  = cnt;

    always_comb begin
        sum_i = acc_i + AW'(x_i) + RND;
        sum_q = acc_q + AW'(x_q) + RND;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            y_out_i   <= '0;
            y_out_q   <= '0;
            acc_i     <= '0;
            acc_q     <= '0;
            cnt       <= '0;
            mode_r    <= mode;
        end else begin
            mode_r <= mode;

            // A completed transfer empties the output register unless a new
            // result lands on the same edge (handled below, overriding this).
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (mode_chg) begin
                // Partial block is dropped; a pending output is left alone.
                acc_i <= '0;
                acc_q <= '0;
                cnt   <= '0;
            end else if (accept) begin
                if (mode_r) begin
                    y_out_i   <= x_i;
                    y_out_q   <= x_q;
                    out_valid <= 1'b1;
                end else if (blk_last) begin
                    // Arithmetic shift, then truncate: the average always fits DW.
                    y_out_i   <= DW'(sum_i >>> LOG2_N);
                    y_out_q   <= DW'(sum_q >>> LOG2_N);
                    out_valid <= 1'b1;
                    acc_i     <= '0;
                    acc_q     <= '0;
                    cnt       <= '0;
                end else begin
                    acc_i <= acc_i + AW'(x_i);
                    acc_q <= acc_q + AW'(x_q);
                    cnt   <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_iq_mavg_pipe.sv
// Directed bench for iq_mavg_pipe: LOG2_N = 2 for the block tests, LOG2_N = 0 and 3
// for the streaming test. Expected values depend on IQ_MAVG_ROUND_EN.

module tb_iq_mavg_pipe;

`ifdef IQ_MAVG_ROUND_EN
    localparam bit RND_ON = 1'b1;
`else
    localparam bit RND_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mode = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic signed [15:0] x_i = '0;
    logic signed [15:0] x_q = '0;

    logic               in_ready, out_valid;
    logic signed [15:0] y_out_i, y_out_q;
    logic [1:0]         blk_cnt;

    logic               in_ready0, out_valid0;
    logic signed [15:0] y0_i, y0_q;
    logic [0:0]         blk_cnt0;

    logic               in_ready3, out_valid3;
    logic signed [15:0] y3_i, y3_q;
    logic [2:0]         blk_cnt3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    iq_mavg_pipe #(.DW(16), .LOG2_N(2)) dut (
        .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .x_i(x_i), .x_q(x_q), .out_valid(out_valid), .out_ready(out_ready),
        .y_out_i(y_out_i), .y_out_q(y_out_q), .blk_cnt(blk_cnt));

    iq_mavg_pipe #(.DW(16), .LOG2_N(0)) dut0 (
        .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_ready(in_ready0),
        .x_i(x_i), .x_q(x_q), .out_valid(out_valid0), .out_ready(out_ready),
        .y_out_i(y0_i), .y_out_q(y0_q), .blk_cnt(blk_cnt0));

    iq_mavg_pipe #(.DW(16), .LOG2_N(3)) dut3 (
        .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_ready(in_ready3),
        .x_i(x_i), .x_q(x_q), .out_valid(out_valid3), .out_ready(out_ready),
        .y_out_i(y3_i), .y_out_q(y3_q), .blk_cnt(blk_cnt3));

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and clock it in.
    task automatic push(input int vi, input int vq);
        x_i = 16'(vi);
        x_q = 16'(vq);
        in_valid = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mode = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        tick();
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        n_cmp++; if (y_out_i !== 16'sd0 || y_out_q !== 16'sd0) begin n_err++; $display("FAIL reset_y got=%0d,%0d want=0,0", y_out_i, y_out_q); end
        n_cmp++; if (blk_cnt !== 2'd0) begin n_err++; $display("FAIL reset_blk_cnt got=%0d want=0", blk_cnt); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%0b want=0", in_ready); end
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got=%0b want=1", in_ready); end
    endtask

    task automatic test_ramp();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push(k, k + 4);
            if (k < 3) begin
                n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ramp_early_valid k=%0d got=%0b want=0", k, out_valid); end
                n_cmp++; if (blk_cnt !== 2'(k + 1)) begin n_err++; $display("FAIL ramp_blk_cnt k=%0d got=%0d want=%0d", k, blk_cnt, k + 1); end
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ramp_valid got=%0b want=1", out_valid); end
        n_cmp++; if (y_out_i !== (RND_ON ? 16'sd2 : 16'sd1)) begin n_err++; $display("FAIL ramp_y_i got=%0d want=%0d", y_out_i, RND_ON ? 2 : 1); end
        n_cmp++; if (y_out_q !== (RND_ON ? 16'sd6 : 16'sd5)) begin n_err++; $display("FAIL ramp_y_q got=%0d want=%0d", y_out_q, RND_ON ? 6 : 5); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ramp_single_pulse got=%0b want=0", out_valid); end
        n_cmp++; if (y_out_i !== (RND_ON ? 16'sd2 : 16'sd1)) begin n_err++; $display("FAIL ramp_y_keep got=%0d", y_out_i); end
    endtask

    task automatic test_negative();
        do_reset();
        push(-1, -32768);
        push(-1, -32768);
        push(-1, -32768);
        push(-2, -32768);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL neg_valid got=%0b want=1", out_valid); end
        n_cmp++; if (y_out_i !== (RND_ON ? -16'sd1 : -16'sd2)) begin n_err++; $display("FAIL neg_y_i got=%0d want=%0d", y_out_i, RND_ON ? -1 : -2); end
        n_cmp++; if (y_out_q !== -16'sd32768) begin n_err++; $display("FAIL neg_y_q got=%0d want=-32768", y_out_q); end
    endtask

    task automatic test_backpressure();
        do_reset();
        push(10, 1);
        push(20, 1);
        push(30, 1);
        push(40, 1);
        out_ready = 1'b0;
        x_i = 16'sd5;
        x_q = -16'sd3;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got=%0b want=0", in_ready); end
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || y_out_i !== 16'sd25 || y_out_q !== 16'sd1 || blk_cnt !== 2'd0 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold c=%0d got v=%0b y=%0d,%0d cnt=%0d rdy=%0b want v=1 y=25,1 cnt=0 rdy=0",
                         c, out_valid, y_out_i, y_out_q, blk_cnt, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_rdy got=%0b want=1", in_ready); end
        tick();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || blk_cnt !== 2'd1) begin n_err++; $display("FAIL bp_resume got v=%0b cnt=%0d want v=0 cnt=1", out_valid, blk_cnt); end
        push(5, -3);
        push(5, -3);
        push(5, -3);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || y_out_i !== 16'sd5 || y_out_q !== -16'sd3) begin n_err++; $display("FAIL bp_second got v=%0b y=%0d,%0d want v=1 y=5,-3", out_valid, y_out_i, y_out_q); end
        out_ready = 1'b1;
    endtask

    task automatic test_mode_switch();
        do_reset();
        push(9, 9);
        push(9, 9);
        n_cmp++; if (blk_cnt !== 2'd2) begin n_err++; $display("FAIL ms_blk_cnt got=%0d want=2", blk_cnt); end
        mode = 1'b1;
        x_i = 16'sd100;
        x_q = -16'sd7;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ms_chg_rdy got=%0b want=0", in_ready); end
        tick();
        n_cmp++; if (blk_cnt !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL ms_after_chg got cnt=%0d v=%0b rdy=%0b want 0,0,1", blk_cnt, out_valid, in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || y_out_i !== 16'sd100 || y_out_q !== -16'sd7) begin n_err++; $display("FAIL ms_byp1 got v=%0b y=%0d,%0d want 1 100,-7", out_valid, y_out_i, y_out_q); end
        push(-7, 100);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || y_out_i !== -16'sd7 || y_out_q !== 16'sd100 || blk_cnt !== 2'd0) begin n_err++; $display("FAIL ms_byp2 got v=%0b y=%0d,%0d cnt=%0d want 1 -7,100 0", out_valid, y_out_i, y_out_q, blk_cnt); end
        tick();
        n_cmp++; if (out_valid !== 1'b0 || y_out_i !== -16'sd7) begin n_err++; $display("FAIL ms_drain got v=%0b y=%0d want 0 -7", out_valid, y_out_i); end
        mode = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_block();
        do_reset();
        push(1, 1);
        push(2, 2);
        push(3, 3);
        reset = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rmb_rdy got=%0b want=0", in_ready); end
        tick();
        reset = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || blk_cnt !== 2'd0) begin n_err++; $display("FAIL rmb_state got v=%0b cnt=%0d want 0,0", out_valid, blk_cnt); end
        push(8, 0);
        push(8, 0);
        push(8, 0);
        push(8, 0);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || y_out_i !== 16'sd8 || y_out_q !== 16'sd0) begin n_err++; $display("FAIL rmb_result got v=%0b y=%0d,%0d want 1 8,0", out_valid, y_out_i, y_out_q); end
    endtask

    task automatic test_back_to_back();
        int s_i, s_q, c3, n0, n3, e_i, e_q, vi, vq;
        bit exp3;
        int rnd3;
        rnd3 = RND_ON ? 4 : 0;
        s_i = 0; s_q = 0; c3 = 0; n0 = 0; n3 = 0;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            vi = k * 37 - 1000;
            vq = 3 - k * 511;
            x_i = 16'(vi);
            x_q = 16'(vq);
            in_valid = 1'b1;
            #1;
            n_cmp++; if (in_ready0 !== 1'b1 || in_ready3 !== 1'b1) begin n_err++; $display("FAIL stream_rdy k=%0d got=%0b,%0b want=1,1", k, in_ready0, in_ready3); end
            s_i += vi; s_q += vq; c3++;
            exp3 = (c3 == 8);
            e_i = (s_i + rnd3) >>> 3;
            e_q = (s_q + rnd3) >>> 3;
            tick();
            if (out_valid0 === 1'b1) n0++;
            if (out_valid3 === 1'b1) n3++;
            n_cmp++; if (out_valid0 !== 1'b1 || y0_i !== 16'(vi) || y0_q !== 16'(vq)) begin n_err++; $display("FAIL stream_n1 k=%0d got v=%0b y=%0d,%0d want 1 %0d,%0d", k, out_valid0, y0_i, y0_q, vi, vq); end
            n_cmp++; if (out_valid3 !== exp3) begin n_err++; $display("FAIL stream_n8_valid k=%0d got=%0b want=%0b", k, out_valid3, exp3); end
            if (exp3) begin
                n_cmp++; if (y3_i !== 16'(e_i) || y3_q !== 16'(e_q)) begin n_err++; $display("FAIL stream_n8_y k=%0d got=%0d,%0d want=%0d,%0d", k, y3_i, y3_q, e_i, e_q); end
                s_i = 0; s_q = 0; c3 = 0;
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (n0 !== 64) begin n_err++; $display("FAIL stream_n1_count got=%0d want=64", n0); end
        n_cmp++; if (n3 !== 8) begin n_err++; $display("FAIL stream_n8_count got=%0d want=8", n3); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_negative();
        test_backpressure();
        test_mode_switch();
        test_reset_mid_block();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
